fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline, and the consumer of the branch unit's NextPCSrc decision.
- Holds the PC and drives the instruction-memory address. Captures the fetched word into the IF/ID register.
- On a taken branch or jump resolved in EX, redirects the PC and squashes the two younger instructions (IF/ID and ID/EX).

---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I IF stage holding the PC and IF/ID register; redirects and squashes on taken branches.
// Optional FETCH_PERF_EN adds FetchCount / RedirectCount performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NextPCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        Stall,
    output logic [31:0] PC,
    input  logic [31:0] ImemInst,
    output logic [31:0] IfIdInst,
    output logic [31:0] IfIdPC,
    output logic [31:0] IfIdPCInc,
    output logic        IfIdValid,
    output logic        FlushIdEx,
`ifdef FETCH_PERF_EN
    output logic [31:0] FetchCount,
    output logic [31:0] RedirectCount,
`endif
    output logic        FetchMisaligned
);
    typedef enum logic {BOOT, RUN} state_t;
    state_t state, next_state;
    logic redirect, advance;
    logic [31:0] pc_inc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= next_state;
    end
    always_comb begin
        next_state = RUN;
    end
    // Redirect outranks stall; BOOT masks both because the pipeline is empty.
    always_comb begin
        redirect  = (state == RUN) & NextPCSrc;
        advance   = (state == RUN) & ~NextPCSrc & ~Stall;
        FlushIdEx = redirect;
    end
    assign pc_inc = PC + 32'd4;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC              <= {RESET_PC[31:2], 2'b00};
            IfIdInst        <= NOP_INST;
            IfIdPC          <= 32'h0;
            IfIdPCInc       <= 32'h0;
            IfIdValid       <= 1'b0;
            FetchMisaligned <= 1'b0;
        end else if (redirect) begin
            PC              <= {BranchTarget[31:2], 2'b00};
            IfIdInst        <= NOP_INST;
            IfIdValid       <= 1'b0;
            FetchMisaligned <= |BranchTarget[1:0];
        end else if (advance) begin
            PC              <= {pc_inc[31:2], 2'b00};
            IfIdInst        <= ImemInst;
            IfIdPC          <= PC;
            IfIdPCInc       <= pc_inc;
            IfIdValid       <= 1'b1;
            FetchMisaligned <= 1'b0;
        end else begin
            FetchMisaligned <= 1'b0;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FetchCount    <= 32'h0;
            RedirectCount <= 32'h0;
        end else begin
            FetchCount    <= FetchCount + {31'h0, advance};
            RedirectCount <= RedirectCount + {31'h0, redirect};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and a randomized model comparison for fetch_unit.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, NextPCSrc = 1'b0, Stall = 1'b0;
    logic [31:0] BranchTarget = 32'h0, ImemInst;
    logic [31:0] PC, IfIdInst, IfIdPC, IfIdPCInc;
    logic        IfIdValid, FlushIdEx, FetchMisaligned;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount, RedirectCount;
`endif
    int n_checks = 0, n_fail = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .BranchTarget(BranchTarget),
        .Stall(Stall), .PC(PC), .ImemInst(ImemInst), .IfIdInst(IfIdInst),
        .IfIdPC(IfIdPC), .IfIdPCInc(IfIdPCInc), .IfIdValid(IfIdValid),
        .FlushIdEx(FlushIdEx),
`ifdef FETCH_PERF_EN
        .FetchCount(FetchCount), .RedirectCount(RedirectCount),
`endif
        .FetchMisaligned(FetchMisaligned)
    );

    always #5 clk = ~clk;
    assign ImemInst = 32'h1000_0000 + PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic n, input logic [31:0] t, input logic s);
        @(negedge clk);
        rst = r; NextPCSrc = n; BranchTarget = t; Stall = s;
        #1;
    endtask

    typedef struct {
        logic        nps;
        logic [31:0] tgt;
        logic        stall;
        logic        flush;
        logic [31:0] pc, inst, ifpc;
        logic        valid, mis;
    } vec_t;
    vec_t tbl[20];

    // reference model state
    logic [31:0] m_pc, m_inst, m_ifpc, m_inc, m_fc, m_rc;
    logic        m_valid, m_mis, m_boot;

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h13; m_ifpc = 0; m_inc = 0;
        m_valid = 0; m_mis = 0; m_boot = 1; m_fc = 0; m_rc = 0;
    endtask

    task automatic model_edge(input logic r, input logic n, input logic [31:0] t, input logic s);
        if (r) model_reset();
        else if (m_boot) m_boot = 0;
        else if (n) begin
            m_pc = t & 32'hFFFF_FFFC; m_inst = 32'h13; m_valid = 0;
            m_mis = (t % 4) != 0; m_rc = m_rc + 1;
        end else if (s) m_mis = 0;
        else begin
            m_ifpc = m_pc; m_inc = m_pc + 4; m_inst = 32'h1000_0000 + m_pc;
            m_valid = 1; m_pc = m_pc + 4; m_mis = 0; m_fc = m_fc + 1;
        end
    endtask

    initial begin
        //          nps   tgt            stl  flush pc            inst           ifpc           v  mis
        tbl[0]  = '{1'b1, 32'h80,        1'b0, 1'b0, 32'h0,        32'h13,        32'h0,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h4,        32'h1000_0000, 32'h0,         1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h8,        32'h1000_0004, 32'h4,         1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hC,        32'h1000_0008, 32'h8,         1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h10,       32'h1000_000C, 32'hC,         1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h40,        1'b0, 1'b1, 32'h40,       32'h13,        32'hC,         1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h44,       32'h1000_0040, 32'h40,        1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h1C,        1'b0, 1'b1, 32'h1C,       32'h13,        32'h40,        1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h20,       32'h1000_001C, 32'h1C,        1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h20,       32'h1000_001C, 32'h1C,        1'b1, 1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h20,       32'h1000_001C, 32'h1C,        1'b1, 1'b0};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h20,       32'h1000_001C, 32'h1C,        1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h24,       32'h1000_0020, 32'h20,        1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'h106,       1'b1, 1'b1, 32'h104,      32'h13,        32'h20,        1'b0, 1'b1};
        tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h108,      32'h1000_0104, 32'h104,       1'b1, 1'b0};
        tbl[15] = '{1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h13,       32'h104,       1'b0, 1'b0};
        tbl[16] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0FFF_FFF8, 32'hFFFF_FFF8, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0FFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h4,        32'h1000_0000, 32'h0,         1'b1, 1'b0};
        tbl[19] = '{1'b1, 32'h203,       1'b0, 1'b1, 32'h200,      32'h13,        32'h0,         1'b0, 1'b1};

        NextPCSrc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_inst", IfIdInst, 32'h13);
        chk("reset_ifpc", IfIdPC, 32'h0);
        chk("reset_inc", IfIdPCInc, 32'h0);
        chk("reset_valid", {31'h0, IfIdValid}, 32'h0);
        chk("reset_mis", {31'h0, FetchMisaligned}, 32'h0);
        chk("reset_flush", {31'h0, FlushIdEx}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            drive(1'b0, tbl[i].nps, tbl[i].tgt, tbl[i].stall);
            chk($sformatf("v%0d_flush", i), {31'h0, FlushIdEx}, {31'h0, tbl[i].flush});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), PC, tbl[i].pc);
            chk($sformatf("v%0d_inst", i), IfIdInst, tbl[i].inst);
            chk($sformatf("v%0d_ifpc", i), IfIdPC, tbl[i].ifpc);
            chk($sformatf("v%0d_inc", i), IfIdPCInc, i == 0 ? 32'h0 : tbl[i].ifpc + 32'd4);
            chk($sformatf("v%0d_valid", i), {31'h0, IfIdValid}, {31'h0, tbl[i].valid});
            chk($sformatf("v%0d_mis", i), {31'h0, FetchMisaligned}, {31'h0, tbl[i].mis});
        end

        // asynchronous reset landing mid-cycle during a redirect
        drive(1'b0, 1'b1, 32'h300, 1'b0);
        chk("mid_flush_pre", {31'h0, FlushIdEx}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_valid", {31'h0, IfIdValid}, 32'h0);
        chk("mid_rst_flush", {31'h0, FlushIdEx}, 32'h0);
        chk("mid_rst_mis", {31'h0, FetchMisaligned}, 32'h0);
        chk("mid_rst_inst", IfIdInst, 32'h13);

        // BOOT ignores redirect, then wrap sequence with counters
        drive(1'b0, 1'b1, 32'h80, 1'b0);
        chk("boot_flush", {31'h0, FlushIdEx}, 32'h0);
        @(posedge clk); #1;
        chk("boot_pc", PC, 32'h0);
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        @(posedge clk); #1;
        chk("wrap_pc0", PC, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("wrap_pc%0d", i + 1), PC, 32'hFFFF_FFFC + 32'd4 * i);
        end
`ifdef FETCH_PERF_EN
        chk("wrap_redirects", RedirectCount, 32'd1);
        chk("wrap_fetches", FetchCount, 32'd3);
`endif

        // randomized run against the reference model
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < 500; i++) begin
            logic r, n, s;
            logic [31:0] t;
            r = $urandom_range(0, 99) < 3;
            n = $urandom_range(0, 99) < 20;
            s = $urandom_range(0, 99) < 25;
            t = $urandom;
            drive(r, n, t, s);
            chk("rnd_flush", {31'h0, FlushIdEx}, {31'h0, !r && !m_boot && n});
            @(posedge clk); #1;
            model_edge(r, n, t, s);
            chk("rnd_pc", PC, m_pc);
            chk("rnd_inst", IfIdInst, m_inst);
            chk("rnd_ifpc", IfIdPC, m_ifpc);
            chk("rnd_inc", IfIdPCInc, m_inc);
            chk("rnd_valid", {31'h0, IfIdValid}, {31'h0, m_valid});
            chk("rnd_mis", {31'h0, FetchMisaligned}, {31'h0, m_mis});
`ifdef FETCH_PERF_EN
            chk("rnd_fetches", FetchCount, m_fc);
            chk("rnd_redirects", RedirectCount, m_rc);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
